ram_fifo_ctrl: RTL and testbench
================================

Name: ram_fifo_ctrl

Overview:
Single-clock FIFO controller that owns one external simple-dual-port RAM: one write port, one synchronous read port, 1-cycle read latency, read-under-write undefined. Upstream it accepts a valid/ready stream and generates the RAM write port. Downstream it generates the RAM read port and captures rd_data into a 2-entry output buffer, presenting a full-throughput valid/ready stream. It hides RAM read latency and never reads an address in the same cycle it is written.

Parameters:
DATA_WIDTH, 32, stream and RAM word width
ADDR_WIDTH, 5, RAM address width; RAM depth DEPTH = 2**ADDR_WIDTH
AFULL_LEVEL, 28, total-occupancy threshold for almost_full (optional feature only)

Ports:
clk  in  1  single clock; all logic on posedge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  upstream word valid
in_ready  out  1  FIFO can accept a word
in_data  in  DATA_WIDTH  upstream word
out_valid  out  1  head word valid
out_ready  in  1  downstream accepts head
out_data  out  DATA_WIDTH  head word
ram_wr_en  out  1  RAM write enable
ram_wr_addr  out  ADDR_WIDTH  RAM write address
ram_wr_data  out  DATA_WIDTH  RAM write data
ram_rd_en  out  1  RAM read enable
ram_rd_addr  out  ADDR_WIDTH  RAM read address
ram_rd_data  in  DATA_WIDTH  RAM read data, valid one cycle after ram_rd_en
level  out  ADDR_WIDTH+2  total words held (RAM + in-flight + output buffer)
empty  out  1  level == 0

Behaviour:
- Reset (rst_n low at posedge): wr_ptr=0, rd_ptr=0, ram_count=0, in-flight flag=0, output buffer empty. Outputs: in_ready=0 during reset, then 1; out_valid=0; out_data=0; level=0; empty=1; ram_wr_en=0; ram_rd_en=0. Reset mid-stream discards all contents, including an in-flight read.
- Write: push = in_valid & in_ready. in_ready = (ram_count < DEPTH), combinational from registers, never from out_ready. On push: ram_wr_en=1, ram_wr_addr=wr_ptr, ram_wr_data=in_data (combinational pass-through); wr_ptr increments mod DEPTH.
- Read issue: ram_rd_en=1 when ram_count>0 and (buf_count + inflight) < 2, counted after this cycle's pop. ram_rd_addr=rd_ptr; rd_ptr increments mod DEPTH; inflight set for one cycle. ram_count counts only words written in earlier cycles, so a read never targets the address being written in the same cycle.
- Capture: cycle after issue, ram_rd_data is written into the output buffer (2-entry FIFO, head drives out_data/out_valid). Capture and pop in the same cycle are legal.
- Pop: out_valid & out_ready. Head advances. out_data holds value while out_valid & !out_ready.
- ram_count: +1 on push, -1 on read issue, unchanged if both. level = ram_count + inflight + buf_count.
- Latency: push in cycle N into empty FIFO gives read issue at N+1 and out_valid at N+2. Sustained throughput is 1 word/cycle with out_ready held high.
- Full: level == DEPTH+2 is reachable; in_ready=0 once ram_count==DEPTH. Push with in_ready=0 is ignored.
- Pointer wrap: ADDR_WIDTH-bit pointers wrap DEPTH-1 -> 0 with no bubble.
- Simultaneous push+pop at full RAM: in_ready reflects only the registered ram_count, so a pop does not allow a push in the same cycle.

Optional Feature:
Macro RAM_FIFO_AFULL_EN.
- Defined: adds output port almost_full (1 bit), registered, =1 when next-cycle level >= AFULL_LEVEL; reset value 0.
- Undefined: port and logic absent; AFULL_LEVEL unused.

Test Plan:
- Reset, then single push in_data=0xA5A5_0001 at cycle N, out_ready=1 -> ram_wr_en/addr 0 at N, ram_rd_en addr 0 at N+1, out_valid with 0xA5A5_0001 at N+2, level returns 0, empty=1.
- Back-to-back 100 pushes of an incrementing pattern with out_ready=1 -> output order preserved, no bubbles after the first word, pointers wrap past 31 -> 0 three times.
- out_ready=0, push until in_ready=0 -> exactly 34 words accepted (level=34). Then release out_ready -> 34 words out in order, no read ever issued to an address written the same cycle (assertion).
- Random in_valid/out_ready at 50% for 10k cycles -> scoreboard match, level never exceeds 34, and 0 <= buf_count + inflight <= 2.
- Assert rst_n low for 1 cycle with 10 words stored and a read in flight -> next cycle out_valid=0, level=0. A subsequent push of 0x1 emerges as the first word.
- With RAM_FIFO_AFULL_EN, AFULL_LEVEL=28 -> almost_full rises in the cycle level reaches 28 and falls when level drops to 27.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: single-clock FIFO controller that owns an external simple-dual-port
// RAM with a 1-cycle synchronous read. A 2-entry output buffer, with a bypass from the
// RAM read data, hides the read latency and sustains one word per cycle.
// Optional feature: define RAM_FIFO_AFULL_EN to add the registered almost_full output.
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
`ifdef RAM_FIFO_AFULL_EN
    ,
    parameter int AFULL_LEVEL = 28
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  empty
`ifdef RAM_FIFO_AFULL_EN
    ,
    output logic                  almost_full
`endif
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam int LW = ADDR_WIDTH + 2;
    localparam logic [CW-1:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         ram_count_q, ram_count_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] buf_mem_q [2];
    logic [DATA_WIDTH-1:0] buf_mem_d [2];
    logic                  buf_head_q, buf_head_d;
    logic [1:0]            buf_count_q, buf_count_d;

    logic                  push;
    logic                  pop;
    logic                  issue;
    logic                  capture;
    logic [2:0]            occ_after;

    // Handshakes and the read-issue decision; ram_count only covers words written in
    // earlier cycles, so a read can never hit the address being written this cycle.
    always_comb begin
        in_ready  = rst_n & (ram_count_q != DEPTH_C);
        push      = in_valid & in_ready;
        out_valid = (buf_count_q != 2'd0) | inflight_q;
        pop       = out_valid & out_ready;
        occ_after = 3'(buf_count_q) + 3'(inflight_q) - 3'(pop);
        issue     = rst_n & (ram_count_q != '0) & (occ_after <= 3'd1);
        capture   = inflight_q & ~(pop & (buf_count_q == 2'd0));
    end

    // RAM ports, head word (buffer first, then bypass of the arriving read) and level.
    always_comb begin
        ram_wr_en   = push;
        ram_wr_addr = wr_ptr_q;
        ram_wr_data = in_data;
        ram_rd_en   = issue;
        ram_rd_addr = rd_ptr_q;
        if (buf_count_q != 2'd0) begin
            out_data = buf_mem_q[buf_head_q];
        end else if (inflight_q) begin
            out_data = ram_rd_data;
        end else begin
            out_data = '0;
        end
        level = LW'(ram_count_q) + LW'(inflight_q) + LW'(buf_count_q);
        empty = (level == '0);
    end

    // Next-state for pointers, RAM occupancy, in-flight flag and output buffer.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_count_d = ram_count_q + CW'(push) - CW'(issue);
        inflight_d  = issue;
        buf_mem_d   = buf_mem_q;
        buf_head_d  = buf_head_q;
        buf_count_d = occ_after[1:0];
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (issue) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (pop && (buf_count_q != 2'd0)) begin
            buf_head_d = ~buf_head_q;
        end
        if (capture) begin
            buf_mem_d[buf_head_q ^ buf_count_q[0]] = ram_rd_data;
        end
    end

`ifdef RAM_FIFO_AFULL_EN
    logic [LW-1:0] level_d;
    logic          almost_full_q, almost_full_d;

    // Look-ahead level so the registered flag lines up with the cycle level changes.
    always_comb begin
        level_d       = LW'(ram_count_d) + LW'(inflight_d) + LW'(buf_count_d);
        almost_full_d = (int'(level_d) >= AFULL_LEVEL);
    end

    // Almost-full register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= almost_full_d;
        end
    end

    assign almost_full = almost_full_q;
`endif

    // State registers; reset drops everything including a read still in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ram_count_q  <= '0;
            inflight_q   <= 1'b0;
            buf_mem_q[0] <= '0;
            buf_mem_q[1] <= '0;
            buf_head_q   <= 1'b0;
            buf_count_q  <= 2'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ram_count_q  <= ram_count_d;
            inflight_q   <= inflight_d;
            buf_mem_q[0] <= buf_mem_d[0];
            buf_mem_q[1] <= buf_mem_d[1];
            buf_head_q   <= buf_head_d;
            buf_count_q  <= buf_count_d;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: bench for ram_fifo_ctrl with a behavioural RAM and a scoreboard queue.
module tb_ram_fifo_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        ram_wr_en;
    logic [4:0]  ram_wr_addr;
    logic [31:0] ram_wr_data;
    logic        ram_rd_en;
    logic [4:0]  ram_rd_addr;
    logic [31:0] ram_rd_data;
    logic [6:0]  level;
    logic        empty;
`ifdef RAM_FIFO_AFULL_EN
    logic        almost_full;
`endif

    ram_fifo_ctrl dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .ram_wr_en(ram_wr_en),
        .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data),
        .ram_rd_en(ram_rd_en),
        .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data),
        .level(level),
        .empty(empty)
`ifdef RAM_FIFO_AFULL_EN
        ,
        .almost_full(almost_full)
`endif
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural simple-dual-port RAM with a 1-cycle synchronous read.
    logic [31:0] ram_mem [32];
    always @(posedge clk) begin
        if (ram_wr_en) ram_mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en) ram_rd_data <= ram_mem[ram_rd_addr];
    end

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] sb [$];
    logic [4:0]  exp_wr_ptr = 5'd0;
    logic [4:0]  exp_rd_ptr = 5'd0;
    logic        last_push;
    logic        last_pop;

    typedef struct {
        logic        in_valid;
        logic [31:0] in_data;
        logic        out_ready;
        logic        exp_wr_en;
        logic [4:0]  exp_wr_addr;
        logic        exp_rd_en;
        logic [4:0]  exp_rd_addr;
        logic        exp_out_valid;
        logic [31:0] exp_out_data;
        logic [6:0]  exp_level;
    } vec_t;
    vec_t vecs [11];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One clock cycle: drive after the rising edge, sample and score on the falling edge.
    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r);
        logic [31:0] exp_word;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(negedge clk);
        last_push = in_valid & in_ready;
        last_pop  = out_valid & out_ready;
        checkOutput("level", 64'(level), 64'(sb.size()));
        checkOutput("empty", 64'(empty), 64'(sb.size() == 0));
`ifdef RAM_FIFO_AFULL_EN
        checkOutput("almost_full", 64'(almost_full), 64'(sb.size() >= 28));
`endif
        if (ram_wr_en && ram_rd_en)
            checkOutput("rd_wr_same_addr", 64'(ram_rd_addr == ram_wr_addr), 64'(0));
        checkOutput("ram_wr_en", 64'(ram_wr_en), 64'(last_push));
        if (last_push) begin
            checkOutput("ram_wr_addr", 64'(ram_wr_addr), 64'(exp_wr_ptr));
            checkOutput("ram_wr_data", 64'(ram_wr_data), 64'(d));
            exp_wr_ptr = exp_wr_ptr + 5'd1;
        end
        if (ram_rd_en) begin
            checkOutput("ram_rd_addr", 64'(ram_rd_addr), 64'(exp_rd_ptr));
            exp_rd_ptr = exp_rd_ptr + 5'd1;
        end
        if (last_pop) begin
            if (sb.size() == 0) begin
                checkOutput("pop_on_empty", 64'(out_valid), 64'(0));
            end else begin
                exp_word = sb.pop_front();
                checkOutput("out_data", 64'(out_data), 64'(exp_word));
            end
        end
        if (last_push) sb.push_back(d);
    endtask

    // Hold rst_n low across the given number of rising edges, then check reset outputs.
    task automatic doReset(input int cycles);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("in_ready_in_reset", 64'(in_ready), 64'(0));
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        exp_wr_ptr = 5'd0;
        exp_rd_ptr = 5'd0;
        @(negedge clk);
        checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
        checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_out_data", 64'(out_data), 64'(0));
        checkOutput("rst_level", 64'(level), 64'(0));
        checkOutput("rst_empty", 64'(empty), 64'(1));
        checkOutput("rst_ram_wr_en", 64'(ram_wr_en), 64'(0));
        checkOutput("rst_ram_rd_en", 64'(ram_rd_en), 64'(0));
    endtask

    initial begin
        int pops;
        int accepted;
        bit started;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;

        // Single-word latency, then a short hold/capture sequence with two words.
        vecs[0]  = '{1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0, 7'd0};
        vecs[1]  = '{1'b0, 32'h0,         1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 32'h0, 7'd1};
        vecs[2]  = '{1'b0, 32'h0,         1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 32'hA5A5_0001, 7'd1};
        vecs[3]  = '{1'b0, 32'h0,         1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0, 7'd0};
        vecs[4]  = '{1'b1, 32'h11,        1'b0, 1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 32'h0, 7'd0};
        vecs[5]  = '{1'b1, 32'h22,        1'b0, 1'b1, 5'd2, 1'b1, 5'd1, 1'b0, 32'h0, 7'd1};
        vecs[6]  = '{1'b0, 32'h0,         1'b0, 1'b0, 5'd0, 1'b1, 5'd2, 1'b1, 32'h11, 7'd2};
        vecs[7]  = '{1'b0, 32'h0,         1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 32'h11, 7'd2};
        vecs[8]  = '{1'b0, 32'h0,         1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 32'h11, 7'd2};
        vecs[9]  = '{1'b0, 32'h0,         1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 32'h22, 7'd1};
        vecs[10] = '{1'b0, 32'h0,         1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0, 7'd0};

        doReset(2);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
            checkOutput("tbl_wr_en", 64'(ram_wr_en), 64'(vecs[i].exp_wr_en));
            if (vecs[i].exp_wr_en) checkOutput("tbl_wr_addr", 64'(ram_wr_addr), 64'(vecs[i].exp_wr_addr));
            checkOutput("tbl_rd_en", 64'(ram_rd_en), 64'(vecs[i].exp_rd_en));
            if (vecs[i].exp_rd_en) checkOutput("tbl_rd_addr", 64'(ram_rd_addr), 64'(vecs[i].exp_rd_addr));
            checkOutput("tbl_out_valid", 64'(out_valid), 64'(vecs[i].exp_out_valid));
            checkOutput("tbl_out_data", 64'(out_data), 64'(vecs[i].exp_out_data));
            checkOutput("tbl_level", 64'(level), 64'(vecs[i].exp_level));
            checkOutput("tbl_empty", 64'(empty), 64'(vecs[i].exp_level == 7'd0));
        end

        // 100 back-to-back words, no bubbles once the stream starts; pointers wrap 3 times.
        pops = 0;
        started = 1'b0;
        for (int i = 0; i < 120 && pops < 100; i++) begin
            applyStimulus(1'(i < 100), 32'h1000_0000 + 32'(i), 1'b1);
            if (started) checkOutput("no_bubble", 64'(out_valid), 64'(1));
            if (last_pop) begin
                started = 1'b1;
                pops++;
            end
        end
        checkOutput("stream_words", 64'(pops), 64'(100));

        // Fill with the sink stalled until in_ready drops.
        accepted = 0;
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'b1, 32'h2000_0000 + 32'(i), 1'b0);
            if (!last_push) break;
            accepted++;
        end
        checkOutput("full_accepted", 64'(accepted), 64'(34));
        checkOutput("full_level", 64'(level), 64'(34));
        checkOutput("full_in_ready", 64'(in_ready), 64'(0));
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0);
        checkOutput("full_push_ignored", 64'(level), 64'(34));
        // A pop at full RAM does not open in_ready in the same cycle.
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1);
        checkOutput("full_pop_in_ready", 64'(in_ready), 64'(0));
        for (int i = 0; i < 60 && sb.size() != 0; i++) applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("drain_empty", 64'(empty), 64'(1));

        // Random traffic at 50% on both sides.
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            if (level > 7'd34) checkOutput("level_bound", 64'(level), 64'(34));
        end
        for (int i = 0; i < 80 && sb.size() != 0; i++) applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("random_drained", 64'(empty), 64'(1));

        // Reset with 10 words stored and a read in flight.
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 32'h3000_0000 + 32'(i), 1'b0);
        repeat (3) applyStimulus(1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("read_before_reset", 64'(ram_rd_en), 64'(1));
        doReset(1);
        applyStimulus(1'b1, 32'h0000_0001, 1'b1);
        repeat (4) applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("post_reset_empty", 64'(empty), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
